xc_sha3_unidx: RTL and testbench
================================

// Module: xc_sha3_unidx
// PURPOSE
//  Inverse of the xc.sha3 lane-index functions: converts a scaled Keccak lane
//  address back to (x,y) state coordinates via multi-cycle iterative mod-5
//  arithmetic behind a valid/ready handshake. Used by the SHA3 load/store
//  sequencer and debug path to map lane offsets to coordinates. Optional
//  inverse-pi mode undoes the yx index mapping.
// PARAMETERS
//  ADDR_W   32  width of req_addr; bits above the decoded lane must be zero
// PORTS
//  g_clk      in   1       single clock, rising edge
//  g_resetn   in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block accepts request (high only in IDLE)
//  req_addr   in   ADDR_W  scaled lane address = lane << req_shamt
//  req_shamt  in   2       post-shift amount used when address was formed
//  req_pi     in   1       1 = undo pi mapping (ignored without macro)
//  rsp_valid  out  1       response present, held until rsp_ready
//  rsp_ready  in   1       consumer accepts response
//  rsp_lane   out  5       decoded lane index 0..24
//  rsp_x      out  3       x coordinate 0..4
//  rsp_y      out  3       y coordinate 0..4
//  rsp_err    out  1       address misaligned or lane > 24; x/y/lane = 0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid, rsp_lane, rsp_x, rsp_y,
//  rsp_err=0. Reset takes effect immediately, including mid-operation;
//  any in-flight request is dropped.
//  States: IDLE, DIV, PI, DONE.
//  IDLE: req_ready=1. Accept on req_valid&req_ready (cycle T). Registers
//   lane = req_addr >> req_shamt.
//   - Low req_shamt bits nonzero, or lane > 24 -> rsp_err=1, go to DONE;
//     rsp_valid at T+1.
//   - Otherwise rem=lane[4:0], y=0, go to DIV.
//  DIV: one step per cycle. If rem>=5: rem-=5, y+=1. Else X=rem, Y=y.
//   Then PI if pi mode is active, otherwise DONE with x=X, y=Y.
//   Non-PI latency: rsp_valid at T+2+floor(lane/5). Max T+6 for lane 24.
//  PI: entered with s = X + 3*Y (5-bit, max 16). Each cycle, if s>=5 then
//   s-=5. Else x=s, y=X; go to DONE.
//   rsp_valid at T+3+floor(lane/5)+floor((X+3Y)/5).
//  DONE: rsp_valid=1. Outputs stay stable until rsp_valid&rsp_ready, then
//   go to IDLE with rsp_valid=0. No new request is accepted in the same
//   cycle (one outstanding op).
//  rsp_lane always reports the decoded lane, never the pi-source lane.
//  All arithmetic is unsigned. Intermediate values never exceed 5 bits.
//  No wrap is possible because range is checked before DIV.
// CONFIGURATION
//  XC_SHA3_UNIDX_PI_EN defined: req_pi is sampled at accept. If 1, run PI:
//   source x=(X+3Y)%5, y=X. This inverts pi X=y, Y=(2x+3y)%5.
//  Undefined: req_pi is ignored, the PI state does not exist, and DIV
//   always goes to DONE.
// TESTING
//  1 addr=0x38, shamt=3, pi=0 -> lane=7, x=2, y=1, err=0; rsp_valid at T+3.
//  2 addr=0x18, shamt=0, pi=0 -> lane=24, x=4, y=4; rsp_valid at T+6.
//  3 addr=0x0E, shamt=2 (misaligned) -> err=1, x=y=lane=0, valid at T+1.
//    addr=25, shamt=0 -> err=1.
//  4 (PI_EN) addr=7, shamt=0, pi=1 -> lane=7, x=0, y=2; valid at T+5.
//    Sweep all 25 (x,y) through the forward yx index; require round-trip.
//  5 Hold rsp_ready=0 for 10 cycles -> outputs stable, req_ready=0,
//    then a single handshake returns to IDLE.
//  6 Assert g_resetn=0 during DIV for lane 20 -> rsp_valid=0 immediately.
//    After release, addr=0 returns x=0, y=0 at T+2.

Source files
------------

// File: rtl/xc_sha3_unidx.sv
// -----------------------------------------------------------------------------
// xc_sha3_unidx
//   Inverse lane-index unit for the xc.sha3 path. Takes a scaled Keccak lane
//   address (lane << req_shamt) and returns the (x,y) state coordinates. It
//   divides by 5 with repeated subtraction, one step per cycle. A
//   valid/ready handshake sits on both sides, and only one operation is in
//   flight at a time.
//
//   Optional build macro XC_SHA3_UNIDX_PI_EN:
//     defined   : req_pi is sampled at accept. When it is 1, an extra PI
//                 phase undoes the pi mapping: x=(X+3Y)%5, y=X.
//     undefined : req_pi is ignored and there is no PI phase.
//
// Ports
//   g_clk      in   1       clock, rising edge
//   g_resetn   in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       high only while idle
//   req_addr   in   ADDR_W  scaled lane address
//   req_shamt  in   2       shift used to form req_addr
//   req_pi     in   1       undo pi mapping (PI build only)
//   rsp_valid  out  1       response present, held until rsp_ready
//   rsp_ready  in   1       consumer accepts response
//   rsp_lane   out  5       decoded lane 0..24
//   rsp_x      out  3       x coordinate 0..4
//   rsp_y      out  3       y coordinate 0..4
//   rsp_err    out  1       misaligned address or lane > 24 (x/y/lane = 0)
//
// States
//   state | meaning
//   IDLE  | waiting for a request, req_ready=1
//   DIV   | repeated subtract-5 on lane: rem -> X, count -> Y
//   PI    | reduce X+3Y mod 5 (PI build only)
//   DONE  | response held until rsp_ready
// -----------------------------------------------------------------------------
module xc_sha3_unidx #(
    parameter int ADDR_W = 32
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_shamt,
    input  logic              req_pi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [4:0]        rsp_lane,
    output logic [2:0]        rsp_x,
    output logic [2:0]        rsp_y,
    output logic              rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
`ifdef XC_SHA3_UNIDX_PI_EN
    localparam logic [1:0] S_PI   = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [4:0]        lane_q;
    logic [4:0]        rem_q;
    logic [2:0]        y_q;

    logic [ADDR_W-1:0] lane_full;
    logic [ADDR_W-1:0] low_mask;
    logic              addr_bad;

`ifdef XC_SHA3_UNIDX_PI_EN
    logic              pi_q;
    logic [2:0]        x_q;
    logic [4:0]        pi_seed;
`else
    // req_pi has no function in this build; route it to a named sink.
    logic              unused_pi;
    assign unused_pi = req_pi;
`endif

    always_comb begin
        lane_full = req_addr >> req_shamt;
        low_mask  = '0;
        case (req_shamt)
            2'd1:    low_mask = ADDR_W'(1);
            2'd2:    low_mask = ADDR_W'(3);
            2'd3:    low_mask = ADDR_W'(7);
            default: low_mask = '0;
        endcase
        // Full-width compare so any nonzero bit above the lane field counts as out of range.
        addr_bad = (|(req_addr & low_mask)) || (lane_full > ADDR_W'(24));
    end

`ifdef XC_SHA3_UNIDX_PI_EN
    // X + 3*Y with X = rem_q (< 5) and Y <= 4, so the maximum is 16.
    assign pi_seed = rem_q + {2'b00, y_q} + {1'b0, y_q, 1'b0};
`endif

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state    <= S_IDLE;
            lane_q   <= '0;
            rem_q    <= '0;
            y_q      <= '0;
            rsp_lane <= '0;
            rsp_x    <= '0;
            rsp_y    <= '0;
            rsp_err  <= 1'b0;
`ifdef XC_SHA3_UNIDX_PI_EN
            pi_q     <= 1'b0;
            x_q      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (addr_bad) begin
                            rsp_err  <= 1'b1;
                            rsp_lane <= '0;
                            rsp_x    <= '0;
                            rsp_y    <= '0;
                            state    <= S_DONE;
                        end else begin
                            lane_q <= lane_full[4:0];
                            rem_q  <= lane_full[4:0];
                            y_q    <= '0;
`ifdef XC_SHA3_UNIDX_PI_EN
                            pi_q   <= req_pi;
`endif
                            state  <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    if (rem_q >= 5'd5) begin
                        rem_q <= rem_q - 5'd5;
                        y_q   <= y_q + 3'd1;
                    end else begin
`ifdef XC_SHA3_UNIDX_PI_EN
                        if (pi_q) begin
                            x_q   <= rem_q[2:0];
                            rem_q <= pi_seed;
                            state <= S_PI;
                        end else begin
                            rsp_err  <= 1'b0;
                            rsp_lane <= lane_q;
                            rsp_x    <= rem_q[2:0];
                            rsp_y    <= y_q;
                            state    <= S_DONE;
                        end
`else
                        rsp_err  <= 1'b0;
                        rsp_lane <= lane_q;
                        rsp_x    <= rem_q[2:0];
                        rsp_y    <= y_q;
                        state    <= S_DONE;
`endif
                    end
                end

`ifdef XC_SHA3_UNIDX_PI_EN
                S_PI: begin
                    if (rem_q >= 5'd5) begin
                        rem_q <= rem_q - 5'd5;
                    end else begin
                        // Source coordinates: x=(X+3Y)%5, y=X. The lane stays the decoded one.
                        rsp_err  <= 1'b0;
                        rsp_lane <= lane_q;
                        rsp_x    <= rem_q[2:0];
                        rsp_y    <= x_q;
                        state    <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_sha3_unidx.sv
module tb_xc_sha3_unidx;

    typedef struct packed {
        logic       err;
        logic [4:0] lane;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] lat;
    } exp_t;

`ifdef XC_SHA3_UNIDX_PI_EN
    localparam bit PI_EN = 1'b1;
`else
    localparam bit PI_EN = 1'b0;
`endif

    logic        g_clk;
    logic        g_resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_shamt;
    logic        req_pi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_lane;
    logic [2:0]  rsp_x;
    logic [2:0]  rsp_y;
    logic        rsp_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   pending = 0;
    bit   first_seen = 0;
    exp_t exp_q;

    xc_sha3_unidx #(.ADDR_W(32)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_shamt (req_shamt),
        .req_pi    (req_pi),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lane  (rsp_lane),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain division/modulo on the lane number.
    function automatic exp_t model(input logic [31:0] addr, input logic [1:0] sh, input logic pi);
        exp_t        e;
        int unsigned l, xx, yy, s;
        l = addr >> sh;
        e = '0;
        if ((addr % (32'd1 << sh)) != 0 || l > 24) begin
            e.err = 1'b1;
            e.lat = 8'd1;
        end else begin
            xx = l % 5;
            yy = l / 5;
            e.lane = 5'(l);
            if (pi && PI_EN) begin
                s     = xx + 3 * yy;
                e.x   = 3'(s % 5);
                e.y   = 3'(xx);
                e.lat = 8'(3 + l / 5 + s / 5);
            end else begin
                e.x   = 3'(xx);
                e.y   = 3'(yy);
                e.lat = 8'(2 + l / 5);
            end
        end
        return e;
    endfunction

    // Single compare process: every cycle the response is up, it must match the model.
    always @(negedge g_clk) begin
        if (g_resetn && pending && rsp_valid) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                chk("latency", cyc - acc_cyc, int'(exp_q.lat));
            end
            chk("rsp_err",   rsp_err,   exp_q.err);
            chk("rsp_lane",  rsp_lane,  exp_q.lane);
            chk("rsp_x",     rsp_x,     exp_q.x);
            chk("rsp_y",     rsp_y,     exp_q.y);
            chk("req_ready_busy", req_ready, 0);
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [1:0] sh, input logic pi);
        exp_q      = model(addr, sh, pi);
        first_seen = 1'b0;
        pending    = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        req_addr   = addr;
        req_shamt  = sh;
        req_pi     = pi;
        req_valid  = 1'b1;
        acc_cyc    = cyc;
        @(posedge g_clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_shamt  = 2'($urandom_range(0, 3));
        req_pi     = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge g_clk); #1;
            n++;
        end
        if (!rsp_valid) chk("rsp_valid_timeout", 0, 1);
    endtask

    task automatic finish_req(input int hold);
        wait_valid();
        repeat (hold) begin
            @(posedge g_clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge g_clk); #1;
        rsp_ready = 1'b0;
        pending   = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
    endtask

    task automatic run_req(input logic [31:0] addr, input logic [1:0] sh, input logic pi, input int hold);
        issue(addr, sh, pi);
        finish_req(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [31:0] a;
        int          l;
        logic [1:0]  sh;

        g_resetn  = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_shamt = '0;
        req_pi    = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_lane",  rsp_lane,  0);
        chk("reset_rsp_x",     rsp_x,     0);
        chk("reset_rsp_y",     rsp_y,     0);
        chk("reset_rsp_err",   rsp_err,   0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // Hand-computed values that pin the reference model.
        e = model(32'h38, 2'd3, 1'b0);
        chk("pin1_lane", e.lane, 7);  chk("pin1_x", e.x, 2);
        chk("pin1_y", e.y, 1);        chk("pin1_lat", e.lat, 3);
        e = model(32'h18, 2'd0, 1'b0);
        chk("pin2_x", e.x, 4);        chk("pin2_y", e.y, 4);
        chk("pin2_lat", e.lat, 6);
        e = model(32'h0E, 2'd2, 1'b0);
        chk("pin3_err", e.err, 1);    chk("pin3_lat", e.lat, 1);
        e = model(32'd25, 2'd0, 1'b0);
        chk("pin3b_err", e.err, 1);
        e = model(32'd7, 2'd0, 1'b1);
`ifdef XC_SHA3_UNIDX_PI_EN
        chk("pin4_x", e.x, 0);        chk("pin4_y", e.y, 2);
        chk("pin4_lat", e.lat, 5);
`else
        chk("pin4_x", e.x, 2);        chk("pin4_y", e.y, 1);
        chk("pin4_lat", e.lat, 3);
`endif

        // Directed cases.
        run_req(32'h38, 2'd3, 1'b0, 0);
        run_req(32'h18, 2'd0, 1'b0, 0);
        run_req(32'h0E, 2'd2, 1'b0, 0);
        run_req(32'd25, 2'd0, 1'b0, 0);
        run_req(32'h100, 2'd3, 1'b0, 0);
        run_req(32'h8000_0000, 2'd0, 1'b0, 0);
        run_req(32'd7, 2'd0, 1'b1, 0);
        run_req(32'h38, 2'd3, 1'b0, 10);

`ifdef XC_SHA3_UNIDX_PI_EN
        // Round trip through the forward pi index for every coordinate.
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                l = y + 5 * ((2 * x + 3 * y) % 5);
                run_req(32'(l) << 2, 2'd2, 1'b1, 0);
                chk("pi_rt_x", rsp_x, x);
                chk("pi_rt_y", rsp_y, y);
                chk("pi_rt_lane", rsp_lane, l);
            end
        end
`else
        for (int l2 = 0; l2 < 25; l2++) run_req(32'(l2) << 1, 2'd1, 1'b0, 0);
`endif

        // Randomized requests, biased toward legal lanes.
        for (int i = 0; i < 60; i++) begin
            sh = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 31)) << sh;
            case ($urandom_range(0, 5))
                0: a = a | 32'($urandom_range(0, 7));
                1: a = a | (32'd1 << $urandom_range(8, 31));
                default: ;
            endcase
            run_req(a, sh, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset while dividing lane 20: ready must come back at once.
        issue(32'd20, 2'd0, 1'b0);
        @(posedge g_clk); #1;
        pending  = 1'b0;
        g_resetn = 1'b0;
        #1;
        chk("rst_div_rsp_valid", rsp_valid, 0);
        chk("rst_div_req_ready", req_ready, 1);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        run_req(32'd0, 2'd0, 1'b0, 0);

        // Reset while a response is being held.
        issue(32'd13, 2'd0, 1'b0);
        wait_valid();
        pending  = 1'b0;
        g_resetn = 1'b0;
        #1;
        chk("rst_done_rsp_valid", rsp_valid, 0);
        chk("rst_done_rsp_lane", rsp_lane, 0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        run_req(32'd24, 2'd0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
